// File: rtl/cam_pkg.sv
// Shared definitions for the CAM match encoder: default depth, index width
// derivation and the emitter state encoding.
package cam_pkg;

  localparam int DEFAULT_CAM_DEPTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } cam_state_t;

  // A single-row CAM still needs a one-bit index port.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_ADDR_W = addrWidth(DEFAULT_CAM_DEPTH);

endpackage

// File: rtl/cam_lsb_encoder.sv
// Combinational lowest-set-bit encoder: binary index, isolated one-hot mask
// and an exactly-one-bit-set flag for an arbitrary match vector.
module cam_lsb_encoder
  import cam_pkg::*;
#(
  parameter int DEPTH = DEFAULT_CAM_DEPTH,
  parameter int IDX_W = addrWidth(DEPTH)
) (
  input  logic [DEPTH-1:0] i_vector,
  output logic [IDX_W-1:0] o_index,
  output logic [DEPTH-1:0] o_isolate,
  output logic             o_exactlyOne
);

  logic w_found;

  always_comb begin
    o_index = '0;
    w_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_vector[i] && !w_found) begin
        o_index = IDX_W'(i);
        w_found = 1'b1;
      end
    end
  end

  // Two's-complement trick keeps only the lowest set bit.
  assign o_isolate    = i_vector & (~i_vector + DEPTH'(1));
  assign o_exactlyOne = (i_vector != '0) && ((i_vector & (i_vector - DEPTH'(1))) == '0);

endmodule

// File: rtl/cam_match_encoder.sv
// Captures a decoded CAM match vector and streams the matching row indices
// out in ascending order, one per handshake, with hit count and miss pulse.
module cam_match_encoder
  import cam_pkg::*;
#(
  parameter int  CAM_DEPTH = DEFAULT_CAM_DEPTH,
  localparam int ADDR_W    = addrWidth(CAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 match_valid,
  output logic                 match_ready,
  input  logic [CAM_DEPTH-1:0] decoded_match_address,
  input  logic                 flush,
  output logic                 addr_valid,
  input  logic                 addr_ready,
  output logic [ADDR_W-1:0]    match_addr,
  output logic                 addr_last,
  output logic [ADDR_W:0]      hit_count,
  output logic                 miss,
  output logic                 busy
);

  cam_state_t           r_state;
  logic [CAM_DEPTH-1:0] r_pending;
  logic [ADDR_W:0]      r_hitCount;
  logic                 r_miss;

  logic [ADDR_W-1:0]    w_lowIndex;
  logic [CAM_DEPTH-1:0] w_lowMask;
  logic                 w_exactlyOne;
  logic [ADDR_W:0]      w_popCount;

  cam_lsb_encoder #(
    .DEPTH (CAM_DEPTH),
    .IDX_W (ADDR_W)
  ) u_lsbEncoder (
    .i_vector     (r_pending),
    .o_index      (w_lowIndex),
    .o_isolate    (w_lowMask),
    .o_exactlyOne (w_exactlyOne)
  );

  always_comb begin
    w_popCount = '0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      w_popCount = w_popCount + (ADDR_W+1)'(decoded_match_address[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_hitCount <= '0;
      r_miss     <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        IDLE: begin
          if (match_valid) begin
            r_pending  <= decoded_match_address;
            r_hitCount <= w_popCount;
            if (decoded_match_address == '0) begin
              r_miss <= 1'b1;
            end else begin
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          // An aborted index is dropped even if the consumer took it this cycle.
          if (flush) begin
            r_pending <= '0;
            r_state   <= IDLE;
          end else if (addr_ready) begin
            r_pending <= r_pending & ~w_lowMask;
            if (w_exactlyOne) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign match_ready = (r_state == IDLE);
  assign addr_valid  = (r_state == EMIT);
  assign busy        = (r_state == EMIT);
  assign match_addr  = w_lowIndex;
  assign addr_last   = (r_state == EMIT) && w_exactlyOne;
  assign hit_count   = r_hitCount;
  assign miss        = r_miss;

endmodule
